// File: rtl/eth_pkg.sv
// Shared constants, state encoding and helpers for the Ethernet frame transmitter.
package eth_pkg;

    localparam int ETH_MAC_LEN       = 6;
    localparam int ETH_ETHERTYPE_LEN = 2;
    localparam int ETH_CRC_LEN       = 4;
    localparam int ETH_MIN_PAYLOAD   = 46;
    localparam int ETH_HDR_LEN       = 2 * ETH_MAC_LEN + ETH_ETHERTYPE_LEN;

    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [7:0]  SFD      = 8'hD5;
    localparam logic [7:0]  PRE      = 8'h55;

    typedef logic [2:0] state_t;

    localparam state_t StIdle = 3'd0;
    localparam state_t StPre  = 3'd1;
    localparam state_t StHdr  = 3'd2;
    localparam state_t StPay  = 3'd3;
    localparam state_t StPad  = 3'd4;
    localparam state_t StFcs  = 3'd5;
    localparam state_t StGap  = 3'd6;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/crc32_lane.sv
// Reflected CRC-32 that absorbs LANE_W bits per cycle, or shifts the register out
// LANE_W bits at a time (filling with ones) while the FCS is being sent.
module crc32_lane
    import eth_pkg::*;
#(
    parameter int LANE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              shift,
    input  logic              inclk,
    input  logic [LANE_W-1:0] in,
    output logic [31:0]       out
);

    logic [31:0]              crc_q;
    logic [LANE_W:0][31:0]    stage;

    assign stage[0] = crc_q;

    for (genvar i = 0; i < LANE_W; i++) begin : g_bit
        assign stage[i+1] = (stage[i] >> 1) ^ ((stage[i][0] ^ in[i]) ? CRC_POLY : 32'h0);
    end

    always_ff @(posedge clk) begin
        if (rst || init) begin
            crc_q <= CRC_INIT;
        end else if (inclk) begin
            crc_q <= stage[LANE_W];
        end else if (shift) begin
            crc_q <= {{LANE_W{1'b1}}, crc_q[31:LANE_W]};
        end
    end

    assign out = crc_q;

endmodule

// File: rtl/eth_frame_tx.sv
// Ethernet frame transmitter emitting preamble..FCS as LANE_W-bit lanes, then the gap.
// Define ETH_TX_PAD_EN to zero-pad short payloads to the 46-byte minimum.
module eth_frame_tx
    import eth_pkg::*;
#(
    parameter int LANE_W         = 2,
    parameter int PREAMBLE_BYTES = 7,
    parameter int GAP_BYTES      = 12,
    parameter int MAX_PAYLOAD    = 1500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [47:0]       dst_mac,
    input  logic [47:0]       src_mac,
    input  logic [15:0]       ethertype,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [LANE_W-1:0] out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int BPL = 8 / LANE_W;
    localparam int LCW = (BPL > 1) ? $clog2(BPL) : 1;
    localparam logic [LCW-1:0] LANE_LAST = LCW'(BPL - 1);

    state_t         state_q, state_d;
    logic [LCW-1:0] lane_q, lane_d;
    logic [10:0]    cnt_q, cnt_d, cnt_next;
    logic [7:0]     sh_q, sh_d;
    logic [111:0]   hdr_q, hdr_d;
    logic           last_q, last_d;
    logic           bad_q, bad_d;
    logic           lane_end, req;
    logic           crc_init, crc_inclk, crc_shift;
    logic [31:0]    crc;
    logic [LANE_W-1:0] fcs_lane;
    logic           unused_crc;

    assign lane_end = (lane_q == LANE_LAST);
    assign cnt_next = sat_inc(cnt_q);

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        hdr_d     = hdr_q;
        last_d    = last_q;
        bad_d     = bad_q;
        in_ready  = 1'b0;
        err       = 1'b0;
        done      = 1'b0;
        req       = 1'b0;
        crc_init  = 1'b0;
        crc_inclk = (state_q == StHdr) || (state_q == StPay) || (state_q == StPad);
        crc_shift = (state_q == StFcs);

        if (state_q != StIdle) begin
            lane_d = lane_end ? '0 : lane_q + LCW'(1);
            if (!lane_end) sh_d = sh_q >> LANE_W;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    hdr_d   = {dst_mac, src_mac, ethertype};
                    state_d = StPre;
                    lane_d  = '0;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    bad_d   = 1'b0;
                    sh_d    = (PREAMBLE_BYTES == 0) ? SFD : PRE;
                end
            end
            StPre: begin
                if (lane_end) begin
                    if (cnt_q == 11'(PREAMBLE_BYTES)) begin
                        crc_init = 1'b1;
                        state_d  = StHdr;
                        cnt_d    = '0;
                        sh_d     = hdr_q[111:104];
                        hdr_d    = hdr_q << 8;
                    end else begin
                        cnt_d = cnt_next;
                        sh_d  = (cnt_next == 11'(PREAMBLE_BYTES)) ? SFD : PRE;
                    end
                end
            end
            StHdr: begin
                if (lane_end) begin
                    if (cnt_q == 11'(ETH_HDR_LEN - 1)) begin
                        cnt_d = '0;
                        req   = 1'b1;
                    end else begin
                        cnt_d = cnt_next;
                        sh_d  = hdr_q[111:104];
                        hdr_d = hdr_q << 8;
                    end
                end
            end
            StPay: begin
                if (lane_end) begin
                    if (last_q) begin
`ifdef ETH_TX_PAD_EN
                        if (cnt_q < 11'(ETH_MIN_PAYLOAD)) begin
                            state_d = StPad;
                            sh_d    = 8'h00;
                            cnt_d   = cnt_next;
                        end else begin
                            state_d = StFcs;
                            cnt_d   = '0;
                        end
`else
                        state_d = StFcs;
                        cnt_d   = '0;
`endif
                    end else if (cnt_q >= 11'(MAX_PAYLOAD)) begin
                        err     = 1'b1;
                        bad_d   = 1'b1;
                        state_d = StFcs;
                        cnt_d   = '0;
                    end else begin
                        req = 1'b1;
                    end
                end
            end
`ifdef ETH_TX_PAD_EN
            StPad: begin
                if (lane_end) begin
                    if (cnt_q >= 11'(ETH_MIN_PAYLOAD)) begin
                        state_d = StFcs;
                        cnt_d   = '0;
                    end else begin
                        sh_d  = 8'h00;
                        cnt_d = cnt_next;
                    end
                end
            end
`endif
            StFcs: begin
                if (lane_end) begin
                    if (cnt_q == 11'(ETH_CRC_LEN - 1)) begin
                        state_d = StGap;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_next;
                    end
                end
            end
            StGap: begin
                if (lane_end) begin
                    if (cnt_q == 11'(GAP_BYTES - 1)) begin
                        done    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_next;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Payload request on the last lane of the previous byte; a miss is an underrun.
        if (req) begin
            in_ready = 1'b1;
            if (in_valid) begin
                state_d = StPay;
                sh_d    = in_byte;
                last_d  = in_last;
                cnt_d   = (state_q == StHdr) ? 11'd1 : cnt_next;
            end else begin
                err     = 1'b1;
                bad_d   = 1'b1;
                state_d = StFcs;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            lane_q  <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            hdr_q   <= '0;
            last_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            hdr_q   <= hdr_d;
            last_q  <= last_d;
            bad_q   <= bad_d;
        end
    end

    crc32_lane #(
        .LANE_W(LANE_W)
    ) u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (crc_init),
        .shift(crc_shift),
        .inclk(crc_inclk),
        .in   (sh_q[LANE_W-1:0]),
        .out  (crc)
    );

    // An aborted frame sends the register uncomplemented so the receiver's check fails.
    assign fcs_lane   = bad_q ? crc[LANE_W-1:0] : ~crc[LANE_W-1:0];
    assign unused_crc = ^crc;

    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StPre) || (state_q == StHdr) || (state_q == StPay) ||
                       (state_q == StPad) || (state_q == StFcs);
    assign out       = !out_valid ? '0 : ((state_q == StFcs) ? fcs_lane : sh_q[LANE_W-1:0]);

endmodule
